// File: rtl/sequenciador_medida.sv
// rtl/sequenciador_medida.sv - periodic distance measurement sequencer (trigger, wait, load, interval)
module sequenciador_medida #(
  parameter int T_TIMEOUT   = 1500000,
  parameter int T_INTERVALO = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  output logic       mede,
  output logic       load,
  output logic       falha,
  output logic [7:0] contagem,
  output logic [2:0] db_estado
);

  localparam logic [2:0] INICIAL   = 3'd0;
  localparam logic [2:0] DISPARA   = 3'd1;
  localparam logic [2:0] ESPERA    = 3'd2;
  localparam logic [2:0] CARREGA   = 3'd3;
  localparam logic [2:0] INTERVALO = 3'd4;
  localparam logic [2:0] ERRO      = 3'd5;

  // Last timer value of each timed state; the state is left on the edge
  // that ends the cycle in which the timer shows this value.
  localparam logic [23:0] TIMEOUT_LAST   = 24'(T_TIMEOUT - 1);
  localparam logic [23:0] INTERVALO_LAST = 24'(T_INTERVALO - 1);

  logic [2:0]  estado;
  logic [2:0]  proximo;
  logic [23:0] timer;

  // Next-state decode; in ESPERA, losing ligar beats data, and data beats timeout.
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:   proximo = ligar ? DISPARA : INICIAL;
      DISPARA:   proximo = ESPERA;
      ESPERA: begin
        if (!ligar)
          proximo = INICIAL;
        else if (fim_medida)
          proximo = CARREGA;
        else if (timer == TIMEOUT_LAST)
          proximo = ERRO;
        else
          proximo = ESPERA;
      end
      CARREGA:   proximo = INTERVALO;
      INTERVALO: begin
        if (timer == INTERVALO_LAST)
          proximo = ligar ? DISPARA : INICIAL;
        else
          proximo = INTERVALO;
      end
      ERRO:      proximo = INTERVALO;
      default:   proximo = INICIAL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      estado <= INICIAL;
    else
      estado <= proximo;
  end

  // Shared cycle timer: zeroed on any state change, counts only in the timed states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= 24'd0;
    else if (proximo != estado)
      timer <= 24'd0;
    else if (estado == ESPERA || estado == INTERVALO)
      timer <= timer + 24'd1;
  end

  // Success counter and sticky failure flag, updated on the exit edge of CARREGA/ERRO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contagem <= 8'd0;
      falha    <= 1'b0;
    end else if (estado == CARREGA) begin
      contagem <= contagem + 8'd1;
      falha    <= 1'b0;
    end else if (estado == ERRO) begin
      falha    <= 1'b1;
    end
  end

  // Strobes come straight from the state register so they can never overlap.
  assign mede      = (estado == DISPARA);
  assign load      = (estado == CARREGA);
  assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_medida.sv
// tb/tb_sequenciador_medida.sv - scoreboard bench for sequenciador_medida
module tb_sequenciador_medida;

  localparam logic [2:0] S_INICIAL   = 3'd0;
  localparam logic [2:0] S_DISPARA   = 3'd1;
  localparam logic [2:0] S_ESPERA    = 3'd2;
  localparam logic [2:0] S_CARREGA   = 3'd3;
  localparam logic [2:0] S_INTERVALO = 3'd4;
  localparam logic [2:0] S_ERRO      = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       fim_medida = 1'b0;
  logic       mede, load, falha;
  logic [7:0] contagem;
  logic [2:0] db_estado;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n;

  typedef struct {
    logic [7:0] cnt;
    logic       f;
    int         at;
  } exp_t;
  exp_t sb[$];

  sequenciador_medida #(.T_TIMEOUT(8), .T_INTERVALO(5)) dut (
    .clk(clk), .reset(reset), .ligar(ligar), .fim_medida(fim_medida),
    .mede(mede), .load(load), .falha(falha), .contagem(contagem), .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every load pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (mede && load) begin
      failures++;
      $display("FAIL overlap mede=%0b load=%0b", mede, load);
    end
    if (load) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_load actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("load_contagem", {24'd0, contagem}, {24'd0, e.cnt});
        chk("load_falha", {31'd0, falha}, {31'd0, e.f});
        chk("load_latency", cyc, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int i = 0; i < 60 && db_estado != s; i++) tick();
    chk(name, {29'd0, db_estado}, {29'd0, s});
  endtask

  // Raise fim_medida now; the load is expected on the next cycle.
  task automatic expect_load(input logic [7:0] cnt, input logic f);
    exp_t e;
    e.cnt = cnt;
    e.f = f;
    e.at = cyc + 1;
    sb.push_back(e);
    fim_medida = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("reset_outputs", {19'd0, mede, load, falha, contagem, db_estado},
        32'd0);
    reset = 1'b0;
    tick();
    chk("idle_inicial", {29'd0, db_estado}, {29'd0, S_INICIAL});

    // Basic success: fim_medida 3 cycles after mede
    ligar = 1'b1;
    wait_state(S_DISPARA, "t1_dispara");
    chk("t1_mede", {31'd0, mede}, 32'd1);
    tick(); tick(); tick();
    expect_load(8'd0, 1'b0);
    tick();
    fim_medida = 1'b0;
    chk("t1_carrega", {29'd0, db_estado}, {29'd0, S_CARREGA});
    tick();
    ligar = 1'b0;
    chk("t1_contagem", {24'd0, contagem}, 32'd1);
    chk("t1_falha", {31'd0, falha}, 32'd0);
    wait_state(S_INICIAL, "t1_back_inicial");

    // Timeout, retry after interval, success clears falha
    reset = 1'b1; tick(); reset = 1'b0;
    ligar = 1'b1;
    wait_state(S_DISPARA, "t2_dispara");
    tick();
    n = 0;
    while (db_estado == S_ESPERA && n < 20) begin n++; tick(); end
    chk("t2_espera_cycles", n, 8);
    chk("t2_erro", {29'd0, db_estado}, {29'd0, S_ERRO});
    tick();
    chk("t2_falha_set", {31'd0, falha}, 32'd1);
    n = 0;
    while (db_estado == S_INTERVALO && n < 20) begin n++; tick(); end
    chk("t2_intervalo_cycles", n, 5);
    chk("t2_retry_mede", {31'd0, mede}, 32'd1);
    tick(); tick();
    expect_load(8'd0, 1'b1);
    tick();
    fim_medida = 1'b0;
    tick();
    chk("t2_contagem", {24'd0, contagem}, 32'd1);
    chk("t2_falha_clear", {31'd0, falha}, 32'd0);
    ligar = 1'b0;
    wait_state(S_INICIAL, "t2_back_inicial");

    // Data on the last ESPERA cycle wins over timeout
    ligar = 1'b1;
    wait_state(S_DISPARA, "t3_dispara");
    tick();
    for (int i = 0; i < 7; i++) tick();
    expect_load(8'd1, 1'b0);
    tick();
    fim_medida = 1'b0;
    chk("t3_carrega", {29'd0, db_estado}, {29'd0, S_CARREGA});
    tick();
    chk("t3_falha", {31'd0, falha}, 32'd0);
    chk("t3_contagem", {24'd0, contagem}, 32'd2);
    ligar = 1'b0;
    wait_state(S_INICIAL, "t3_back_inicial");

    // ligar dropped in ESPERA; fim_medida in INICIAL ignored
    ligar = 1'b1;
    wait_state(S_DISPARA, "t4_dispara");
    tick(); tick();
    ligar = 1'b0;
    tick();
    chk("t4_abort_inicial", {29'd0, db_estado}, {29'd0, S_INICIAL});
    fim_medida = 1'b1;
    tick(); tick();
    fim_medida = 1'b0;
    tick();
    chk("t4_still_inicial", {29'd0, db_estado}, {29'd0, S_INICIAL});
    chk("t4_contagem", {24'd0, contagem}, 32'd2);

    // 256 successes: contagem wraps; first one holds fim_medida 4 cycles
    ligar = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_state(S_DISPARA, "t5_dispara");
      tick();
      expect_load(8'((2 + i) % 256), 1'b0);
      if (i == 0) begin
        tick(); tick(); tick(); tick();
      end else begin
        tick();
      end
      fim_medida = 1'b0;
    end
    tick();
    chk("t5_contagem_wrapped", {24'd0, contagem}, 32'd2);

    // Reset during ESPERA and during INTERVALO
    wait_state(S_DISPARA, "t6_dispara");
    tick();
    reset = 1'b1;
    #1;
    chk("t6_reset_espera", {19'd0, mede, load, falha, contagem, db_estado}, 32'd0);
    tick();
    reset = 1'b0;
    wait_state(S_DISPARA, "t6_dispara2");
    tick();
    expect_load(8'd0, 1'b0);
    tick();
    fim_medida = 1'b0;
    tick();
    chk("t6_in_intervalo", {29'd0, db_estado}, {29'd0, S_INTERVALO});
    reset = 1'b1;
    #1;
    chk("t6_reset_intervalo", {19'd0, mede, load, falha, contagem, db_estado}, 32'd0);
    ligar = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t6_waits_inicial", {29'd0, db_estado}, {29'd0, S_INICIAL});

    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequenciador_medida.md
SEQUENCIADOR_MEDIDA -- requirements
Module: sequenciador_medida

Interface
REQ-001 SHALL have parameter T_TIMEOUT, default 1500000, meaning max ESPERA cycles before a measurement is declared failed (30 ms at 50 MHz).
REQ-002 SHALL have parameter T_INTERVALO, default 5000000, meaning cycles spent in INTERVALO between measurements (100 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port ligar, input, 1, level enable for periodic measurement.
REQ-006 SHALL have port fim_medida, input, 1, one-or-more-cycle pulse from the sensor interface: BCD distance valid.
REQ-007 SHALL have port mede, output, 1, one-cycle trigger to the sensor interface.
REQ-008 SHALL have port load, output, 1, one-cycle load strobe to the discretizer register.
REQ-009 SHALL have port falha, output, 1, sticky flag: last measurement timed out.
REQ-010 SHALL have port contagem, output, 8, count of successful loads, modulo 256.
REQ-011 SHALL have port db_estado, output, 3, current state encoding for debug display.

Function
REQ-012 SHALL implement a Moore FSM with states INICIAL=0, DISPARA=1, ESPERA=2, CARREGA=3, INTERVALO=4, ERRO=5; codes 6-7 SHALL go to INICIAL on the next edge.
REQ-013 SHALL contain one 24-bit cycle timer, cleared on every state entry and incremented each cycle in ESPERA and INTERVALO.
REQ-014 INICIAL: ligar=1 -> DISPARA; else stay.
REQ-015 DISPARA: mede=1 for exactly this one cycle; unconditionally -> ESPERA.
REQ-016 ESPERA: fim_medida=1 -> CARREGA; else timer = T_TIMEOUT-1 -> ERRO; else stay.
REQ-017 ESPERA: fim_medida and timeout in the same cycle -> CARREGA (data wins).
REQ-018 ESPERA: ligar=0 -> INICIAL with no load; this check takes priority over REQ-016/017.
REQ-019 CARREGA: load=1 for exactly this one cycle; contagem increments by 1 (255 wraps to 0); falha clears; -> INTERVALO.
REQ-020 ERRO: falha set to 1 on exit edge; lasts one cycle; -> INTERVALO (retry after interval); contagem unchanged.
REQ-021 INTERVALO: timer = T_INTERVALO-1 -> DISPARA if ligar=1, else INICIAL; ligar changes before then SHALL not shorten the interval.
REQ-022 mede and load SHALL be decoded from the state register only: never both high, never high outside DISPARA/CARREGA respectively.
REQ-023 fim_medida outside ESPERA SHALL be ignored; a multi-cycle fim_medida SHALL produce only one load.
REQ-024 Latency: fim_medida sampled high in ESPERA at edge N -> load high during cycle N..N+1 (one cycle after).
REQ-025 db_estado SHALL equal the state encoding at all times.

Reset
REQ-026 reset=1 SHALL, asynchronously, force state INICIAL, timer 0, contagem 0, falha 0, mede 0, load 0, db_estado 0.
REQ-027 reset asserted mid-measurement SHALL abort without a load pulse; after release the FSM SHALL wait in INICIAL for ligar.

Verification (T_TIMEOUT=8, T_INTERVALO=5)
REQ-028 Reset, ligar=1, fim_medida pulse 3 cycles after mede -> one mede pulse, one load pulse one cycle after fim_medida, contagem=1, falha=0.
REQ-029 ligar=1, fim_medida never -> ERRO after 8 ESPERA cycles, falha=1, no load, retry mede 5 cycles after INTERVALO entry; next success clears falha, contagem=1.
REQ-030 fim_medida asserted exactly on the 8th ESPERA cycle -> CARREGA, load=1, falha stays 0.
REQ-031 ligar dropped in ESPERA -> INICIAL next edge, no load, contagem unchanged; fim_medida pulses in INICIAL ignored.
REQ-032 256 successful cycles -> contagem wraps 255->0; fim_medida held high 4 cycles -> single load.
REQ-033 reset pulsed during ESPERA and during INTERVALO -> all outputs 0 immediately, db_estado=0, no load.
